projectile_motion: RTL

- Downstream consumer of the per-throw `speed` value.
- On a launch strobe it latches speed and throw direction, then steps a ballistic projectile once per frame tick: constant horizontal velocity, vertical velocity with gravity.
- Publishes the projectile position to the draw stage and reports how the flight ended (ground, screen edge, or wall) to the game-control FSM.

---
 rtl/projectile_motion.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/projectile_motion.sv
// projectile_motion: steps a launched projectile once per frame tick and
// reports how the flight ended (ground, screen edge or wall).
// Optional wall collision is compiled in when WALL_COLLISION_EN is defined.
module projectile_motion #(
    parameter int FRAME_TICKS   = 1_000_000,
    parameter int START_X_LEFT  = 100,
    parameter int START_X_RIGHT = 900,
    parameter int START_Y       = 600,
    parameter int GROUND_Y      = 700,
    parameter int SCREEN_W      = 1024,
    parameter int V_UP          = 16,
    parameter int GRAVITY       = 1
`ifdef WALL_COLLISION_EN
    ,
    parameter int WALL_X_MIN    = 500,
    parameter int WALL_X_MAX    = 524,
    parameter int WALL_TOP_Y    = 450
`endif
) (
    input  logic        clk60MHz,
    input  logic        rst,
    input  logic        launch,
    input  logic [4:0]  speed,
    input  logic        turn,
    output logic [10:0] x_pos,
    output logic [10:0] y_pos,
    output logic        in_flight,
    output logic        land_pulse,
    output logic [1:0]  end_code
);

    localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, FLIGHT, DONE} state_t;

    state_t state, state_nxt;

    logic [TICK_W-1:0] tick;
    logic [10:0]       x;        // always on screen, so unsigned
    logic signed [12:0] y;       // may go above the screen (negative)
    logic [4:0]        vx;
    logic              dir;
    logic signed [7:0] vy;
    logic [1:0]        code;

    // Step datapath signals
    logic signed [12:0] x_n;
    logic signed [12:0] y_n;
    logic signed [8:0]  vy_sum;
    logic               step;
    logic               edge_hit;
    logic               wall_hit;
    logic               ground_hit;
    logic               end_hit;

    // State register
    always_ff @(posedge clk60MHz) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (launch)  state_nxt = FLIGHT;
            FLIGHT:  if (end_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: flags from state, position from the registers
    always_comb begin
        in_flight  = (state == FLIGHT);
        land_pulse = (state == DONE);
        end_code   = code;
        x_pos      = x;
        if (y[12])      y_pos = 11'd0;
        else if (y[11]) y_pos = 11'h7ff;
        else            y_pos = y[10:0];
    end

    // Candidate next position and end-of-flight conditions for this step
    always_comb begin
        step = (state == FLIGHT) && (tick == TICK_W'(FRAME_TICKS - 1));
        if (dir) x_n = $signed({2'b00, x}) - $signed({8'b0, vx});
        else     x_n = $signed({2'b00, x}) + $signed({8'b0, vx});
        y_n    = y + {{5{vy[7]}}, vy};
        vy_sum = $signed({vy[7], vy}) + $signed(9'(GRAVITY));
        edge_hit   = (x_n < 13'sd0) || (x_n > $signed(13'(SCREEN_W - 1)));
`ifdef WALL_COLLISION_EN
        wall_hit   = (x_n >= $signed(13'(WALL_X_MIN))) &&
                     (x_n <= $signed(13'(WALL_X_MAX))) &&
                     (y_n >= $signed(13'(WALL_TOP_Y)));
`else
        wall_hit   = 1'b0;
`endif
        ground_hit = (y_n >= $signed(13'(GROUND_Y)));
        end_hit    = step && (edge_hit || wall_hit || ground_hit);
    end

    // Projectile registers: load on launch, advance on each frame step
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            tick <= '0;
            x    <= '0;
            y    <= '0;
            vx   <= '0;
            dir  <= 1'b0;
            vy   <= '0;
            code <= 2'd0;
        end else if (state == IDLE) begin
            if (launch) begin
                tick <= '0;
                x    <= turn ? 11'(START_X_RIGHT) : 11'(START_X_LEFT);
                y    <= 13'(START_Y);
                vx   <= speed;
                dir  <= turn;
                vy   <= 8'(-V_UP);
                code <= 2'd0;
            end
        end else if (state == FLIGHT) begin
            if (step) begin
                tick <= '0;
                // Velocity saturates at +127 to stay within 8 bits
                if (vy_sum > 9'sd127) vy <= 8'sd127;
                else                  vy <= vy_sum[7:0];
                if (edge_hit) begin
                    x    <= (x_n < 13'sd0) ? 11'd0 : 11'(SCREEN_W - 1);
                    y    <= y_n;
                    code <= 2'd1;
                end else if (wall_hit) begin
                    x    <= x_n[10:0];
                    y    <= y_n;
                    code <= 2'd2;
                end else if (ground_hit) begin
                    x    <= x_n[10:0];
                    y    <= 13'(GROUND_Y);
                    code <= 2'd0;
                end else begin
                    x    <= x_n[10:0];
                    y    <= y_n;
                end
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end
    end

endmodule
